led_status_controller: RTL and testbench

Parametrised, registered successor to the board LED status block. It drives the LEDR bank with three fields: the FSM state, one selectable page of status data, and the cleaned switch bits. It adds an alert blink on the state field and a pulse-stretched event overlay on the page field, so one-cycle events stay visible. It also has a freeze (hold) mode. It sits at the top level between the controller FSM, the input conditioning blocks and the LEDR pins.

---
 rtl/led_ctrl_pkg.sv | 25 ++
 rtl/led_pulse_stretcher.sv | 59 +++++
 rtl/led_status_controller.sv | 120 ++++++++++++
 tb/tb_led_status_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg
// Shared defaults and field-placement helpers for the LED status controller.
//   DEF_STATE_W / DEF_PAGE_W / DEF_SW_W : default field widths
//   DEF_BLINK_DIV                       : default blink half-period in cycles
//   DEF_STRETCH_CYCLES                  : default event overlay hold time
//   state_lsb(), page_lsb()             : LSB position of each LEDR field
package led_ctrl_pkg;

   localparam int DEF_STATE_W        = 3;
   localparam int DEF_PAGE_W         = 4;
   localparam int DEF_SW_W           = 3;
   localparam int DEF_BLINK_DIV      = 25_000_000;
   localparam int DEF_STRETCH_CYCLES = 12_500_000;

   // State field occupies the MSBs of LEDR.
   function automatic int state_lsb(input int num_leds, input int state_w);
      return num_leds - state_w;
   endfunction

   // Page field sits directly above the switch field.
   function automatic int page_lsb(input int sw_w);
      return sw_w;
   endfunction

endpackage

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
// Stretches single-cycle strobes so they stay visible for CYCLES cycles.
// New strobes while active OR into the mask and restart the hold time.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   pulse  : W single-cycle event strobes
//   active : high while a hold is running or a strobe is present now
//   mask   : accumulated strobes, including those arriving this cycle
module led_pulse_stretcher
   import led_ctrl_pkg::*;
#(
   parameter int W      = DEF_PAGE_W,
   parameter int CYCLES = DEF_STRETCH_CYCLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] pulse,
   output logic         active,
   output logic [W-1:0] mask
);

   localparam int              CNT_W  = $clog2(CYCLES);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [W-1:0]     mask_reg, mask_next;
   logic             any_pulse;

   always_comb begin
      any_pulse = |pulse;
      cnt_next  = cnt_reg;
      mask_next = mask_reg;
      if (any_pulse) begin
         // Load when idle, retrigger when running (including the last cycle).
         cnt_next  = RELOAD;
         mask_next = (cnt_reg == '0) ? pulse : (mask_reg | pulse);
      end else if (cnt_reg != '0) begin
         cnt_next = cnt_reg - CNT_W'(1);
         // Mask clears on the same edge the counter returns to zero.
         if (cnt_reg == CNT_W'(1)) begin
            mask_next = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg  <= '0;
         mask_reg <= '0;
      end else begin
         cnt_reg  <= cnt_next;
         mask_reg <= mask_next;
      end
   end

   assign active = any_pulse | (cnt_reg != '0);
   assign mask   = mask_reg | pulse;

endmodule

// File: rtl/led_status_controller.sv
// led_status_controller
// Registered LEDR driver: {state field, page/event field, switch field}.
//   CLOCK_50    : clock
//   RESET_N     : asynchronous active-low reset
//   State       : FSM state, shown in the MSB field (blinks while Alert)
//   Page_Data   : packed pages, page k = [k*PAGE_W +: PAGE_W]
//   Page_Sel    : selected page index (out-of-range selects show 0)
//   Sw_Bits     : cleaned switch bits, shown in the LSB field
//   Event_Pulse : single-cycle strobes, stretched over the page field
//   Alert       : blink the state field while high
//   Freeze      : hold LEDR while high (timers keep running)
//   LEDR        : LED drive, active-high, one cycle of latency
module led_status_controller
   import led_ctrl_pkg::*;
#(
   parameter int STATE_W        = DEF_STATE_W,
   parameter int PAGE_W         = DEF_PAGE_W,
   parameter int SW_W           = DEF_SW_W,
   parameter int NUM_LEDS       = 10,
   parameter int NUM_PAGES      = 4,
   parameter int BLINK_DIV      = DEF_BLINK_DIV,
   parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES
) (
   input  logic                          CLOCK_50,
   input  logic                          RESET_N,
   input  logic [STATE_W-1:0]            State,
   input  logic [NUM_PAGES*PAGE_W-1:0]   Page_Data,
   input  logic [$clog2(NUM_PAGES)-1:0]  Page_Sel,
   input  logic [SW_W-1:0]               Sw_Bits,
   input  logic [PAGE_W-1:0]             Event_Pulse,
   input  logic                          Alert,
   input  logic                          Freeze,
   output logic [NUM_LEDS-1:0]           LEDR
);

   localparam int BLINK_W   = $clog2(BLINK_DIV);
   localparam int STATE_LSB = state_lsb(NUM_LEDS, STATE_W);
   localparam int PAGE_LSB  = page_lsb(SW_W);

   if (NUM_LEDS != STATE_W + PAGE_W + SW_W) begin : g_bad_layout
      $error("NUM_LEDS must equal STATE_W + PAGE_W + SW_W");
   end
   if (NUM_PAGES < 2 || BLINK_DIV < 2 || STRETCH_CYCLES < 2) begin : g_bad_param
      $error("NUM_PAGES, BLINK_DIV and STRETCH_CYCLES must be >= 2");
   end

   // Free-running blink divider; never gated by Alert or Freeze.
   logic [BLINK_W-1:0] blink_cnt_reg;
   logic               blink_phase_reg;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b1;
      end else if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt_reg   <= '0;
         blink_phase_reg <= ~blink_phase_reg;
      end else begin
         blink_cnt_reg   <= blink_cnt_reg + BLINK_W'(1);
      end
   end

   // Event overlay keeps running during Freeze so held events survive it.
   logic              ev_active;
   logic [PAGE_W-1:0] ev_mask;

   led_pulse_stretcher #(
      .W      (PAGE_W),
      .CYCLES (STRETCH_CYCLES)
   ) u_stretch (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .pulse  (Event_Pulse),
      .active (ev_active),
      .mask   (ev_mask)
   );

   // Page select; indices beyond NUM_PAGES fall through to zero.
   logic [PAGE_W-1:0] pages [NUM_PAGES];
   logic [PAGE_W-1:0] page_sel_data;

   for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_page
      assign pages[gi] = Page_Data[gi*PAGE_W +: PAGE_W];
   end

   always_comb begin
      page_sel_data = '0;
      for (int k = 0; k < NUM_PAGES; k++) begin
         if (int'(Page_Sel) == k) begin
            page_sel_data = pages[k];
         end
      end
   end

   logic [STATE_W-1:0]  state_fld;
   logic [PAGE_W-1:0]   page_fld;
   logic [NUM_LEDS-1:0] led_next;

   always_comb begin
      state_fld = Alert ? (State & {STATE_W{blink_phase_reg}}) : State;
      page_fld  = ev_active ? ev_mask : page_sel_data;
      led_next  = '0;
      led_next[STATE_LSB +: STATE_W] = state_fld;
      led_next[PAGE_LSB  +: PAGE_W]  = page_fld;
      led_next[0         +: SW_W]    = Sw_Bits;
   end

   logic [NUM_LEDS-1:0] ledr_reg;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         ledr_reg <= '0;
      end else if (!Freeze) begin
         ledr_reg <= led_next;
      end
   end

   assign LEDR = ledr_reg;

endmodule

// File: tb/tb_led_status_controller.sv
// tb_led_status_controller
// Directed bench for led_status_controller with BLINK_DIV=4, STRETCH_CYCLES=6.
// Inputs change 1 ns after a rising edge; LEDR is checked 1 ns after the
// following rising edge, i.e. one cycle of latency.
module tb_led_status_controller;

   logic        clk;
   logic        rst_n;
   logic [2:0]  state;
   logic [15:0] page_data;
   logic [1:0]  page_sel;
   logic [2:0]  sw_bits;
   logic [3:0]  event_pulse;
   logic        alert;
   logic        freeze;
   logic [9:0]  ledr;

   int vectors     = 0;
   int miscompares = 0;

   led_status_controller #(
      .BLINK_DIV      (4),
      .STRETCH_CYCLES (6)
   ) dut (
      .CLOCK_50    (clk),
      .RESET_N     (rst_n),
      .State       (state),
      .Page_Data   (page_data),
      .Page_Sel    (page_sel),
      .Sw_Bits     (sw_bits),
      .Event_Pulse (event_pulse),
      .Alert       (alert),
      .Freeze      (freeze),
      .LEDR        (ledr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; state = 3'b111; page_data = 16'hFFFF; page_sel = 2'd3;
      sw_bits = 3'b111; event_pulse = 4'hF; alert = 1'b1; freeze = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (ledr !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: LEDR=%b expected %b", i, ledr, 10'h000);
         end
      end
      rst_n = 1'b1; event_pulse = 4'h0; alert = 1'b0;
      state = 3'b101; page_sel = 2'd2; page_data = 16'h4A2F; sw_bits = 3'b011;
      step();
      vectors++;
      if (ledr !== 10'b101_1010_011) begin
         miscompares++;
         $display("FAIL first_update: LEDR=%b expected %b", ledr, 10'b101_1010_011);
      end
   endtask

   task automatic test_blink();
      logic [2:0] exp;
      // Fresh reset so the blink phase is known: edge n after release
      // samples phase 1 for n=1..4, 0 for n=5..8, and so on.
      @(posedge clk); #1;
      rst_n = 1'b0; alert = 1'b1; state = 3'b111;
      step();
      rst_n = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         step();
         exp = (((n - 1) / 4) % 2 == 0) ? 3'b111 : 3'b000;
         vectors++;
         if (ledr[9:7] !== exp) begin
            miscompares++;
            $display("FAIL blink[%0d]: state_field=%b expected %b", n, ledr[9:7], exp);
         end
      end
      alert = 1'b0;
      for (int n = 7; n <= 8; n++) begin
         step();
         vectors++;
         if (ledr[9:7] !== 3'b111) begin
            miscompares++;
            $display("FAIL alert_drop[%0d]: state_field=%b expected %b", n, ledr[9:7], 3'b111);
         end
      end
   endtask

   task automatic test_stretch();
      state = 3'b101; page_sel = 2'd0; sw_bits = 3'b011;
      event_pulse = 4'b0001;
      step();
      event_pulse = 4'b0000;
      for (int i = 0; i < 7; i++) begin
         logic [3:0] exp;
         exp = (i < 6) ? 4'b0001 : 4'hF;
         vectors++;
         if (ledr[6:3] !== exp) begin
            miscompares++;
            $display("FAIL stretch[%0d]: page_field=%b expected %b", i, ledr[6:3], exp);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp;
      event_pulse = 4'b0001;
      step();
      event_pulse = 4'b0000;
      step(); step();
      vectors++;
      if (ledr[6:3] !== 4'b0001) begin
         miscompares++;
         $display("FAIL retrig_pre: page_field=%b expected %b", ledr[6:3], 4'b0001);
      end
      event_pulse = 4'b0100;
      step();
      event_pulse = 4'b0000;
      for (int i = 0; i < 7; i++) begin
         exp = (i < 6) ? 4'b0101 : 4'hF;
         vectors++;
         if (ledr[6:3] !== exp) begin
            miscompares++;
            $display("FAIL retrig[%0d]: page_field=%b expected %b", i, ledr[6:3], exp);
         end
         if (i < 6) step();
      end
   endtask

   task automatic test_freeze();
      logic [3:0] exp;
      freeze = 1'b1; state = 3'b010; sw_bits = 3'b100; page_sel = 2'd1;
      for (int i = 0; i < 3; i++) begin
         event_pulse = (i == 1) ? 4'b1000 : 4'b0000;
         step();
         vectors++;
         if (ledr !== 10'b101_1111_011) begin
            miscompares++;
            $display("FAIL freeze_hold[%0d]: LEDR=%b expected %b", i, ledr, 10'b101_1111_011);
         end
      end
      event_pulse = 4'b0000;
      freeze = 1'b0;
      step();
      vectors++;
      if (ledr !== 10'b010_1000_100) begin
         miscompares++;
         $display("FAIL freeze_release: LEDR=%b expected %b", ledr, 10'b010_1000_100);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         exp = (i < 3) ? 4'b1000 : 4'b0010;
         vectors++;
         if (ledr[6:3] !== exp) begin
            miscompares++;
            $display("FAIL freeze_event[%0d]: page_field=%b expected %b", i, ledr[6:3], exp);
         end
      end
   endtask

   task automatic test_async_reset();
      alert = 1'b1; state = 3'b111; page_sel = 2'd0; sw_bits = 3'b001;
      event_pulse = 4'b0010;
      step();
      event_pulse = 4'b0000;
      step(); step();
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (ledr !== 10'h000) begin
         miscompares++;
         $display("FAIL async_reset: LEDR=%b expected %b", ledr, 10'h000);
      end
      step();
      rst_n = 1'b1;
      step();
      vectors++;
      if (ledr !== 10'b111_1111_001) begin
         miscompares++;
         $display("FAIL post_reset: LEDR=%b expected %b", ledr, 10'b111_1111_001);
      end
      step(); step(); step();
      vectors++;
      if (ledr !== 10'b111_1111_001) begin
         miscompares++;
         $display("FAIL post_reset_on: LEDR=%b expected %b", ledr, 10'b111_1111_001);
      end
      step();
      vectors++;
      if (ledr !== 10'b000_1111_001) begin
         miscompares++;
         $display("FAIL post_reset_off: LEDR=%b expected %b", ledr, 10'b000_1111_001);
      end
   endtask

   initial begin
      test_reset();
      test_blink();
      test_stretch();
      test_back_to_back();
      test_freeze();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation time %0t exceeded limit", $time);
      $fatal(1, "timeout");
   end

endmodule
